// File: rtl/seven_seg_scanner_if.sv
// rtl/seven_seg_scanner_if.sv - host load bus and display drive signals of the seven-segment scanner
interface seven_seg_scanner_if;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        load;
    logic        pending;
    logic [3:0]  char;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    modport master (
        output value, dp_in, digit_en, load,
        input  pending, char, dp, an, frame_done
    );

    modport slave (
        input  value, dp_in, digit_en, load,
        output pending, char, dp, an, frame_done
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - 4-digit multiplexed seven-segment scanner with dead-time and frame-aligned double buffer
module seven_seg_scanner #(
    parameter int DIV  = 50000,
    parameter int DEAD = 500
) (
    input logic                clk,
    input logic                rst_n,
    seven_seg_scanner_if.slave bus
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] DEADC = CW'(DEAD);

    typedef enum logic {S_DEAD, S_ON} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    idx, idx_n;
    logic          last_cnt, boundary;

    logic [15:0] pend_val, act_val, act_val_n;
    logic [3:0]  pend_dp, act_dp, act_dp_n;
    logic [3:0]  pend_en, act_en, act_en_n;
    logic        pending_q;

    logic [3:0] char_n, an_n;
    logic       dp_n, fd_n, shown;

    // Outputs are computed from the next-cycle values so they line up with the registered cnt/idx/state.
    always_comb begin
        last_cnt  = (cnt == LAST);
        boundary  = last_cnt && (idx == 2'd3);
        cnt_n     = last_cnt ? '0 : cnt + 1'b1;
        idx_n     = last_cnt ? idx + 2'd1 : idx;
        state_n   = (cnt_n < DEADC) ? S_DEAD : S_ON;

        act_val_n = act_val;
        act_dp_n  = act_dp;
        act_en_n  = act_en;
        if (boundary && pending_q) begin
            act_val_n = pend_val;
            act_dp_n  = pend_dp;
            act_en_n  = pend_en;
        end

        shown  = (state_n == S_ON) && act_en_n[idx_n];
        an_n   = shown ? ~(4'b0001 << idx_n) : 4'b1111;
        dp_n   = shown ? ~act_dp_n[idx_n] : 1'b1;
        char_n = act_val_n[{idx_n, 2'b00} +: 4];
        fd_n   = (cnt_n == LAST) && (idx_n == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_DEAD;
            cnt   <= '0;
            idx   <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    // A load on the boundary edge still transfers the old pending data; the new data waits a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val  <= '0;
            pend_dp   <= '0;
            pend_en   <= '0;
            pending_q <= 1'b0;
            act_val   <= '0;
            act_dp    <= '0;
            act_en    <= '0;
        end else begin
            act_val <= act_val_n;
            act_dp  <= act_dp_n;
            act_en  <= act_en_n;
            if (bus.load) begin
                pend_val  <= bus.value;
                pend_dp   <= bus.dp_in;
                pend_en   <= bus.digit_en;
                pending_q <= 1'b1;
            end else if (boundary) begin
                pending_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.char       <= 4'd0;
            bus.an         <= 4'b1111;
            bus.dp         <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            bus.char       <= char_n;
            bus.an         <= an_n;
            bus.dp         <= dp_n;
            bus.frame_done <= fd_n;
        end
    end

    assign bus.pending = pending_q;
endmodule
